// File: rtl/frame_timing_gen.sv
// Video timing and test-pattern source: PPC pixels per clock, configurable porches,
// frame-aligned start/stop, per-frame pattern latch and a completed-frame counter.
module frame_timing_gen #(
   parameter int DW       = 8,
   parameter int PPC      = 1,
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic [1:0]        mode,
   output logic              frame_vs,
   output logic              frame_hs,
   output logic              frame_de,
   output logic [DW*PPC-1:0] frame_data,
   output logic              frame_vsync,
   output logic              frame_hsync,
   output logic [15:0]       frame_cnt,
   output logic              busy
);

   localparam int HT       = (H_ACTIVE + H_FP + H_SYNC + H_BP) / PPC;
   localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_ACT_C  = H_ACTIVE / PPC;
   localparam int H_SYNC_S = (H_ACTIVE + H_FP) / PPC;
   localparam int H_SYNC_E = (H_ACTIVE + H_FP + H_SYNC) / PPC;
   localparam int V_SYNC_S = V_ACTIVE + V_FP;
   localparam int V_SYNC_E = V_ACTIVE + V_FP + V_SYNC;
   localparam int HW       = $clog2(HT + 1);
   localparam int VW       = $clog2(VT + 1);
   // Coordinate widths keep bit 4 addressable for the checkerboard on tiny rasters.
   localparam int XW       = ($clog2(HT * PPC + 1) > 5) ? $clog2(HT * PPC + 1) : 5;
   localparam int YW       = (VW > 5) ? VW : 5;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [HW-1:0]       hcnt, hcnt_nxt;
   logic [VW-1:0]       vcnt, vcnt_nxt;
   logic [1:0]          mode_q, mode_nxt;
   logic [15:0]         cnt_nxt;
   logic                line_last, frame_last;
   logic                run_nxt, vs_nxt, hs_nxt, de_nxt, vsync_nxt, hsync_nxt;
   logic [DW*PPC-1:0]   data_nxt;
   logic [XW-1:0]       px;
   logic [YW-1:0]       py;
   logic [DW-1:0]       pix;

   assign line_last  = (hcnt == HW'(HT - 1));
   assign frame_last = line_last && (vcnt == VW'(VT - 1));

   // Next raster position, state and frame mode; outputs are decoded from these so the
   // registered stream shows the position the counters hold after the edge.
   always_comb begin
      // NOTE: every variable gets a default up front so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      hcnt_nxt  = hcnt;
      vcnt_nxt  = vcnt;
      mode_nxt  = mode_q;
      cnt_nxt   = frame_cnt;
      unique case (state)
         IDLE: begin
            hcnt_nxt = '0;
            vcnt_nxt = '0;
            if (enable) begin
               state_nxt = RUN;
               mode_nxt  = mode;
            end
         end
         RUN, STOP_PEND: begin
            if (frame_last) begin
               hcnt_nxt = '0;
               vcnt_nxt = '0;
               cnt_nxt  = frame_cnt + 16'd1;
               if (enable) begin
                  state_nxt = RUN;
                  mode_nxt  = mode;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               state_nxt = enable ? RUN : STOP_PEND;
               if (line_last) begin
                  hcnt_nxt = '0;
                  vcnt_nxt = vcnt + 1'b1;
               end else begin
                  hcnt_nxt = hcnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
            vcnt_nxt  = '0;
         end
      endcase
   end

   assign run_nxt   = (state_nxt != IDLE);
   assign vs_nxt    = run_nxt && (vcnt_nxt < VW'(V_ACTIVE));
   assign hs_nxt    = run_nxt && (hcnt_nxt < HW'(H_ACT_C));
   assign de_nxt    = vs_nxt && hs_nxt;
   assign vsync_nxt = run_nxt && (vcnt_nxt >= VW'(V_SYNC_S)) && (vcnt_nxt < VW'(V_SYNC_E));
   assign hsync_nxt = run_nxt && (hcnt_nxt >= HW'(H_SYNC_S)) && (hcnt_nxt < HW'(H_SYNC_E));

   always_comb begin
      data_nxt = '0;
      px       = '0;
      pix      = '0;
      py       = YW'(vcnt_nxt);
      for (int k = 0; k < PPC; k++) begin
         px = XW'(hcnt_nxt) * XW'(PPC) + XW'(k);
         case (mode_nxt)
            2'd0:    pix = DW'(px);
            2'd1:    pix = DW'(py);
            2'd2:    pix = {DW{px[4] ^ py[4]}};
            default: pix = DW'(cnt_nxt);
         endcase
         if (de_nxt) data_nxt[k*DW +: DW] = pix;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         hcnt        <= '0;
         vcnt        <= '0;
         mode_q      <= '0;
         frame_cnt   <= '0;
         frame_vs    <= 1'b0;
         frame_hs    <= 1'b0;
         frame_de    <= 1'b0;
         frame_vsync <= 1'b0;
         frame_hsync <= 1'b0;
         frame_data  <= '0;
         busy        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state       <= state_nxt;
         hcnt        <= hcnt_nxt;
         vcnt        <= vcnt_nxt;
         mode_q      <= mode_nxt;
         frame_cnt   <= cnt_nxt;
         frame_vs    <= vs_nxt;
         frame_hs    <= hs_nxt;
         frame_de    <= de_nxt;
         frame_vsync <= vsync_nxt;
         frame_hsync <= hsync_nxt;
         frame_data  <= data_nxt;
         busy        <= run_nxt;
      end
   end

endmodule

// File: doc/frame_timing_gen.md
Name: frame_timing_gen

Overview:
- Parametrised video timing and test-pattern source that drives a full frame stream: frame_vs, frame_hs, frame_de, frame_vsync, frame_hsync, frame_data.
- Generalises the single-pixel frame stream to PPC pixels per clock, configurable blanking and selectable patterns.
- Sits at the head of 3DNR bring-up/test paths and drives downstream frame sinks directly.
- Provides graceful start/stop on frame boundaries and a frame counter.

Parameters:
- DW, 8, bits per pixel
- PPC, 1, pixels per clock (lanes); every H_* parameter must be a multiple of PPC
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch, pixels
- H_SYNC, 44, horizontal sync width, pixels
- H_BP, 148, horizontal back porch, pixels
- V_ACTIVE, 1080, active lines
- V_FP, 4, vertical front porch, lines
- V_SYNC, 5, vertical sync width, lines
- V_BP, 36, vertical back porch, lines

Ports:
- clk  in  1  pixel-group clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  run request
- mode  in  2  pattern select, latched at frame start
- frame_vs  out  1  high for every clock of vertical-active lines
- frame_hs  out  1  high during horizontal-active clocks of every line
- frame_de  out  1  frame_vs & frame_hs
- frame_data  out  DW*PPC  pixels; lane k in bits [k*DW +: DW]
- frame_vsync  out  1  high during vertical sync lines
- frame_hsync  out  1  high during horizontal sync clocks
- frame_cnt  out  16  completed-frame count
- busy  out  1  high in RUN or STOP_PEND

Behaviour:
- Clock and reset: one clock clk. Reset rstn is asynchronous, active-low. While in reset, all outputs are 0, state is IDLE, counters are 0. Reset assertion mid-frame takes effect immediately.
- Horizontal counter in clocks:
  - hcnt runs 0..HT-1, where HT = (H_ACTIVE+H_FP+H_SYNC+H_BP)/PPC.
  - Line order is active, FP, sync, BP.
  - Active: hcnt < H_ACTIVE/PPC.
  - Sync: (H_ACTIVE+H_FP)/PPC <= hcnt < (H_ACTIVE+H_FP+H_SYNC)/PPC.
- Vertical counter in lines:
  - vcnt runs 0..VT-1, where VT = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - vcnt increments when hcnt wraps.
  - Region order and decode are identical to horizontal.
- State machine:
  - IDLE: counters held at 0, all stream outputs 0. Moves to RUN on enable=1.
  - RUN: counters advance every clock. enable=0 moves to STOP_PEND.
  - STOP_PEND: counters advance. enable=1 returns to RUN. At the last clock of the frame (hcnt=HT-1, vcnt=VT-1), moves to IDLE.
  - RUN with enable=1 at the last clock of the frame wraps to (0,0) seamlessly, with no gap cycle.
- Latency:
  - All outputs are registered.
  - The first clock after the IDLE→RUN edge presents position (0,0): frame_de=1, frame_vs=1, frame_hs=1.
  - Frames are never truncated; a stop only takes effect at the frame end.
- mode latch:
  - mode is sampled into mode_q when entering RUN from IDLE and at each frame wrap.
  - Changes mid-frame have no effect until the next frame.
- Pixel coordinates: x = hcnt*PPC + k for lane k; y = vcnt.
- Patterns (value truncated to DW):
  - 0: horizontal ramp, value x.
  - 1: vertical ramp, value y.
  - 2: checkerboard, all-ones if x[4]^y[4], else 0.
  - 3: solid, value frame_cnt.
  - frame_data is 0 whenever frame_de=0.
- frame_cnt:
  - Increments by 1 in the cycle after the last clock of each frame, in both RUN and STOP_PEND.
  - Wraps 0xFFFF→0.
  - Holds in IDLE; cleared only by reset.
- busy = (state != IDLE), registered together with the stream outputs.
- Simultaneous events: when enable falls exactly on the last frame clock while in RUN, the block finishes that frame and goes IDLE. frame_cnt still increments.

Test Plan:
Bench parameters: PPC=2, DW=8, H=8/2/2/4 (HT=8 clocks), V=4/1/1/2 (VT=8), frame = 64 clocks.
- Start: reset, then enable=1, mode=0 → next clock de=1, data={8'd1,8'd0}. Clock 4: de=0. Clocks 5: hsync=1 (clock 5 only). vsync=1 on line 5 only. frame_cnt=1 after 64 clocks.
- Mode 2 with H_ACTIVE=32 variant → lanes toggle 0x00/0xFF every 16 pixels; phase inverts every 16 lines.
- Stop: drop enable at clock 20 → frame completes through clock 63, busy falls at clock 64, outputs 0, frame_cnt=1. Re-raising enable before clock 63 keeps a continuous stream.
- Mode change mid-frame (0→1 at clock 10) → frame 0 stays a horizontal ramp; frame 1 line y carries data y on all lanes.
- Async reset at clock 37 → all outputs 0 before the next edge. Restart begins at (0,0) with frame_cnt=0.
- Wrap: force 65536 frames (or preload in sim) → frame_cnt 0xFFFF→0x0000; mode 3 data tracks the low byte.
